// File: rtl/id_queue_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_queue_stage_pkg
//  Description : MIPS opcode/funct encodings, ALU operation and branch-type
//                enums, and the decoded-instruction bundle used by the
//                queued instruction-decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_queue_stage_pkg;

   localparam int XLEN = 32;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FUNC_SLL  = 6'h00;
   localparam logic [5:0] FUNC_SRL  = 6'h02;
   localparam logic [5:0] FUNC_SRA  = 6'h03;
   localparam logic [5:0] FUNC_SLLV = 6'h04;
   localparam logic [5:0] FUNC_SRLV = 6'h06;
   localparam logic [5:0] FUNC_SRAV = 6'h07;
   localparam logic [5:0] FUNC_JR   = 6'h08;
   localparam logic [5:0] FUNC_ADD  = 6'h20;
   localparam logic [5:0] FUNC_ADDU = 6'h21;
   localparam logic [5:0] FUNC_SUB  = 6'h22;
   localparam logic [5:0] FUNC_SUBU = 6'h23;
   localparam logic [5:0] FUNC_AND  = 6'h24;
   localparam logic [5:0] FUNC_OR   = 6'h25;
   localparam logic [5:0] FUNC_XOR  = 6'h26;
   localparam logic [5:0] FUNC_NOR  = 6'h27;
   localparam logic [5:0] FUNC_SLT  = 6'h2A;
   localparam logic [5:0] FUNC_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_NOR = 4'd5,
      ALU_SLT = 4'd6,
      ALU_SLL = 4'd7,
      ALU_SRL = 4'd8,
      ALU_SRA = 4'd9
   } aluop_t;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_JR   = 2'b01,
      BR_BEQ  = 2'b10,
      BR_BNE  = 2'b11
   } br_t;

   // Everything EX needs about one instruction; PCs are carried at full
   // 32-bit width and trimmed to PC_W at the stage outputs.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      wr_addr;
      logic            reg_wr;
      logic            mem_rd;
      logic            mem_wr;
      aluop_t          aluop;
      logic            sign;
      logic [XLEN-1:0] ext_imm;
      logic            use_imm;
      br_t             branch;
      logic            illegal;
      logic [XLEN-1:0] jump_target;
      logic [XLEN-1:0] link_val;
   } dec_bundle_t;

   function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage : id_queue_stage_pkg
`default_nettype wire

// File: rtl/id_queue_stage_dec_logic.sv
`default_nettype none
// ============================================================================
//  Module      : dec_logic
//  Description : Purely combinational MIPS decoder: one instruction word plus
//                its PC in, one decoded bundle out, plus the hazard-relevant
//                "reads rt" and "is J/JAL" flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec_logic
   import id_queue_stage_pkg::*;
(
   input  logic [31:0]  ins,
   input  logic [31:0]  pc,
   output dec_bundle_t  dec,
   output logic         reads_rt,
   output logic         is_jump
);

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic [15:0] w_imm;
   logic [31:0] w_pc_plus4;

   assign w_op       = ins[31:26];
   assign w_rs       = ins[25:21];
   assign w_rt       = ins[20:16];
   assign w_rd       = ins[15:11];
   assign w_shamt    = ins[10:6];
   assign w_funct    = ins[5:0];
   assign w_imm      = ins[15:0];
   assign w_pc_plus4 = pc + 32'd4;

   // Field decode; every output starts from a safe "do nothing" default
   always_comb begin
      dec             = '0;
      dec.pc          = pc;
      dec.rs          = w_rs;
      dec.rt          = w_rt;
      dec.aluop       = ALU_ADD;
      dec.branch      = BR_NONE;
      // J/JAL target keeps the top nibble of pc+4, replaces the rest
      dec.jump_target = (w_pc_plus4 & 32'hF000_0000) | {4'h0, ins[25:0], 2'b00};
      dec.link_val    = pc + 32'd8;
      reads_rt        = 1'b0;
      is_jump         = 1'b0;

      case (w_op)
         OP_RTYPE: begin
            reads_rt    = 1'b1;
            dec.ext_imm = {27'h0, w_shamt};
            dec.wr_addr = w_rd;
            dec.reg_wr  = 1'b1;
            case (w_funct)
               FUNC_ADD, FUNC_ADDU: dec.aluop = ALU_ADD;
               FUNC_SUB, FUNC_SUBU: dec.aluop = ALU_SUB;
               FUNC_AND:            dec.aluop = ALU_AND;
               FUNC_OR:             dec.aluop = ALU_OR;
               FUNC_XOR:            dec.aluop = ALU_XOR;
               FUNC_NOR:            dec.aluop = ALU_NOR;
               FUNC_SLT: begin
                  dec.aluop = ALU_SLT;
                  dec.sign  = 1'b1;
               end
               FUNC_SLTU:           dec.aluop = ALU_SLT;
               FUNC_SLL: begin
                  dec.aluop   = ALU_SLL;
                  dec.use_imm = 1'b1;
               end
               FUNC_SRL: begin
                  dec.aluop   = ALU_SRL;
                  dec.use_imm = 1'b1;
               end
               FUNC_SRA: begin
                  dec.aluop   = ALU_SRA;
                  dec.use_imm = 1'b1;
                  dec.sign    = 1'b1;
               end
               FUNC_SLLV:           dec.aluop = ALU_SLL;
               FUNC_SRLV:           dec.aluop = ALU_SRL;
               FUNC_SRAV: begin
                  dec.aluop = ALU_SRA;
                  dec.sign  = 1'b1;
               end
               FUNC_JR: begin
                  dec.branch  = BR_JR;
                  dec.reg_wr  = 1'b0;
                  dec.wr_addr = 5'd0;
               end
               default: begin
                  dec.illegal = 1'b1;
                  dec.reg_wr  = 1'b0;
                  dec.wr_addr = 5'd0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW: begin
            dec.ext_imm = sext16(w_imm);
            dec.use_imm = 1'b1;
            dec.wr_addr = w_rt;
            dec.reg_wr  = 1'b1;
            dec.mem_rd  = (w_op == OP_LW);
         end
         OP_SLTI, OP_SLTIU: begin
            dec.aluop   = ALU_SLT;
            dec.sign    = (w_op == OP_SLTI);
            dec.ext_imm = sext16(w_imm);
            dec.use_imm = 1'b1;
            dec.wr_addr = w_rt;
            dec.reg_wr  = 1'b1;
         end
         OP_ORI, OP_XORI: begin
            dec.aluop   = (w_op == OP_ORI) ? ALU_OR : ALU_XOR;
            dec.ext_imm = {16'h0, w_imm};
            dec.use_imm = 1'b1;
            dec.wr_addr = w_rt;
            dec.reg_wr  = 1'b1;
         end
         OP_LUI: begin
            // rs is r0 in a LUI encoding, so ADD passes the shifted immediate
            dec.ext_imm = {w_imm, 16'h0};
            dec.use_imm = 1'b1;
            dec.wr_addr = w_rt;
            dec.reg_wr  = 1'b1;
         end
         OP_SW: begin
            reads_rt    = 1'b1;
            dec.ext_imm = sext16(w_imm);
            dec.use_imm = 1'b1;
            dec.mem_wr  = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            // EX compares rs and rt by XOR; the offset rides in ext_imm
            reads_rt    = 1'b1;
            dec.aluop   = ALU_XOR;
            dec.ext_imm = sext16(w_imm);
            dec.branch  = (w_op == OP_BEQ) ? BR_BEQ : BR_BNE;
         end
         OP_J: begin
            is_jump = 1'b1;
         end
         OP_JAL: begin
            is_jump     = 1'b1;
            dec.reg_wr  = 1'b1;
            dec.wr_addr = 5'd31;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule : dec_logic
`default_nettype wire

// File: rtl/id_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_queue_stage
//  Description : Decoupled MIPS decode stage. Fetched instructions sit in a
//                circular queue; the head is decoded and moved into a
//                registered bundle towards EX under valid/ready, with a
//                load-use interlock, J/JAL redirect and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_queue_stage
   import id_queue_stage_pkg::*;
#(
   parameter int QDEPTH = 4,    // power of two, >= 2
   parameter int PC_W   = 32    // 28..32
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          if_valid,
   output logic                          if_ready,
   input  logic [31:0]                   if_ins,
   input  logic [PC_W-1:0]               if_pc,
   input  logic                          flush,
   input  logic                          ex_mem_rd,
   input  logic [4:0]                    ex_wr_addr,
   output logic                          id_valid,
   input  logic                          id_ready,
   output logic [PC_W-1:0]               id_pc,
   output logic [4:0]                    rd_addr_a,
   output logic [4:0]                    rd_addr_b,
   output logic [4:0]                    wr_addr,
   output logic                          reg_wr,
   output logic                          mem_rd,
   output logic                          mem_wr,
   output aluop_t                        aluop,
   output logic                          sign,
   output logic [31:0]                   ext_imm,
   output logic                          use_imm,
   output logic [1:0]                    branch,
   output logic                          illegal,
   output logic                          redirect_valid,
   output logic [PC_W-1:0]               redirect_pc,
   output logic [PC_W-1:0]               link_val,
   output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = $clog2(QDEPTH+1);

   logic [31:0]     ins_mem_q [QDEPTH];
   logic [PC_W-1:0] pc_mem_q  [QDEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             id_valid_q, id_valid_d;
   logic             redirect_q, redirect_d;
   dec_bundle_t      bundle_q, bundle_d;

   dec_bundle_t      head_dec;
   logic             head_reads_rt;
   logic             head_is_jump;
   logic             w_hazard;
   logic             w_load;
   logic             w_jump_load;
   logic             w_enq;

   dec_logic u_dec (
      .ins      (ins_mem_q[rd_ptr_q]),
      .pc       (32'(pc_mem_q[rd_ptr_q])),
      .dec      (head_dec),
      .reads_rt (head_reads_rt),
      .is_jump  (head_is_jump)
   );

   // Handshake and interlock terms derived from the current head
   always_comb begin
      w_hazard    = ex_mem_rd && (ex_wr_addr != 5'd0) &&
                    ((ex_wr_addr == head_dec.rs) ||
                     ((ex_wr_addr == head_dec.rt) && head_reads_rt));
      w_load      = (!id_valid_q || id_ready) && (count_q != '0) &&
                    !w_hazard && !flush;
      w_jump_load = w_load && head_is_jump;
      // Entries behind a J/JAL are dead, so nothing is accepted that cycle
      w_enq       = if_valid && if_ready && !w_jump_load && !flush;
   end

   assign if_ready = (count_q != CNT_W'(QDEPTH));

   // Next-state for queue pointers and the output register; flush wins
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      id_valid_d = id_valid_q;
      redirect_d = 1'b0;
      bundle_d   = bundle_q;
      if (flush) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         id_valid_d = 1'b0;
      end else if (w_jump_load) begin
         rd_ptr_d   = wr_ptr_q;
         count_d    = '0;
         id_valid_d = 1'b1;
         redirect_d = 1'b1;
         bundle_d   = head_dec;
      end else begin
         if (w_enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (w_load) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            bundle_d = head_dec;
         end
         count_d    = count_q + CNT_W'(w_enq) - CNT_W'(w_load);
         id_valid_d = w_load ? 1'b1 : (id_ready ? 1'b0 : id_valid_q);
      end
   end

   // Control state and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         id_valid_q <= 1'b0;
         redirect_q <= 1'b0;
         bundle_q   <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         id_valid_q <= id_valid_d;
         redirect_q <= redirect_d;
         bundle_q   <= bundle_d;
      end
   end

   // Queue storage; contents are only meaningful below count_q
   always_ff @(posedge clk) begin
      if (w_enq) begin
         ins_mem_q[wr_ptr_q] <= if_ins;
         pc_mem_q[wr_ptr_q]  <= if_pc;
      end
   end

   assign id_valid       = id_valid_q;
   assign redirect_valid = redirect_q;
   assign q_count        = count_q;
   assign id_pc          = bundle_q.pc[PC_W-1:0];
   assign rd_addr_a      = bundle_q.rs;
   assign rd_addr_b      = bundle_q.rt;
   assign wr_addr        = bundle_q.wr_addr;
   assign reg_wr         = bundle_q.reg_wr;
   assign mem_rd         = bundle_q.mem_rd;
   assign mem_wr         = bundle_q.mem_wr;
   assign aluop          = bundle_q.aluop;
   assign sign           = bundle_q.sign;
   assign ext_imm        = bundle_q.ext_imm;
   assign use_imm        = bundle_q.use_imm;
   assign branch         = bundle_q.branch;
   assign illegal        = bundle_q.illegal;
   assign redirect_pc    = bundle_q.jump_target[PC_W-1:0];
   assign link_val       = bundle_q.link_val[PC_W-1:0];

endmodule : id_queue_stage
`default_nettype wire

// File: tb/tb_id_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_queue_stage
//  Description : Self-checking bench for id_queue_stage: decode vector table
//                plus directed sequences for backpressure, load-use stall,
//                JAL redirect, flush and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_queue_stage;
   import id_queue_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_ins;
   logic [31:0] if_pc;
   logic        flush;
   logic        ex_mem_rd;
   logic [4:0]  ex_wr_addr;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic        reg_wr, mem_rd, mem_wr;
   aluop_t      aluop;
   logic        sign;
   logic [31:0] ext_imm;
   logic        use_imm;
   logic [1:0]  branch;
   logic        illegal;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] link_val;
   logic [2:0]  q_count;

   int checks = 0;
   int errors = 0;

   id_queue_stage #(.QDEPTH(4), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_ins(if_ins), .if_pc(if_pc), .flush(flush), .ex_mem_rd(ex_mem_rd),
      .ex_wr_addr(ex_wr_addr), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .wr_addr(wr_addr), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .aluop(aluop), .sign(sign), .ext_imm(ext_imm), .use_imm(use_imm),
      .branch(branch), .illegal(illegal), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .link_val(link_val), .q_count(q_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      logic [4:0]  wr;
      logic        rw, mrd, mwr;
      logic [3:0]  alu;
      logic        sgn;
      logic [31:0] imm;
      logic        ui;
      logic [1:0]  br;
      logic        ill;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(input logic [31:0] ins, input logic [4:0] wr,
                               input logic rw, input logic mrd, input logic mwr,
                               input logic [3:0] alu, input logic sgn,
                               input logic [31:0] imm, input logic ui,
                               input logic [1:0] br, input logic ill);
      vec_t v;
      v.ins = ins; v.wr = wr; v.rw = rw; v.mrd = mrd; v.mwr = mwr;
      v.alu = alu; v.sgn = sgn; v.imm = imm; v.ui = ui; v.br = br; v.ill = ill;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] ins, input logic [31:0] pc);
      if_valid = 1'b1;
      if_ins   = ins;
      if_pc    = pc;
      step();
      if_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int pushed;
      int seen;
      int vcnt;
      logic acc;

      //                 ins           wr  rw mrd mwr alu       sgn imm           ui br     ill
      vecs[0]  = mk(32'h2001FFFB, 5'd1,  1, 0, 0, ALU_ADD, 0, 32'hFFFF_FFFB, 1, 2'b00, 0); // addi r1,r0,-5
      vecs[1]  = mk(32'h00622020, 5'd4,  1, 0, 0, ALU_ADD, 0, 32'h0000_0000, 0, 2'b00, 0); // add r4,r3,r2
      vecs[2]  = mk(32'h8CC50008, 5'd5,  1, 1, 0, ALU_ADD, 0, 32'h0000_0008, 1, 2'b00, 0); // lw r5,8(r6)
      vecs[3]  = mk(32'hAC47FFFC, 5'd0,  0, 0, 1, ALU_ADD, 0, 32'hFFFF_FFFC, 1, 2'b00, 0); // sw r7,-4(r2)
      vecs[4]  = mk(32'h34288000, 5'd8,  1, 0, 0, ALU_OR,  0, 32'h0000_8000, 1, 2'b00, 0); // ori r8,r1,0x8000
      vecs[5]  = mk(32'h3C091234, 5'd9,  1, 0, 0, ALU_ADD, 0, 32'h1234_0000, 1, 2'b00, 0); // lui r9,0x1234
      vecs[6]  = mk(32'h1422FFFF, 5'd0,  0, 0, 0, ALU_XOR, 0, 32'hFFFF_FFFF, 0, 2'b11, 0); // bne r1,r2,-1
      vecs[7]  = mk(32'h000B50C3, 5'd10, 1, 0, 0, ALU_SRA, 1, 32'h0000_0003, 1, 2'b00, 0); // sra r10,r11,3
      vecs[8]  = mk(32'h03E00008, 5'd0,  0, 0, 0, ALU_ADD, 0, 32'h0000_0000, 0, 2'b01, 0); // jr r31
      vecs[9]  = mk(32'h2C2CFFFF, 5'd12, 1, 0, 0, ALU_SLT, 0, 32'hFFFF_FFFF, 1, 2'b00, 0); // sltiu r12,r1,-1
      vecs[10] = mk(32'hFC000000, 5'd0,  0, 0, 0, ALU_ADD, 0, 32'h0000_0000, 0, 2'b00, 1); // opcode 0x3F
      vecs[11] = mk(32'h0000003F, 5'd0,  0, 0, 0, ALU_ADD, 0, 32'h0000_0000, 0, 2'b00, 1); // funct 0x3F

      rst = 1'b1; if_valid = 1'b0; if_ins = '0; if_pc = '0; flush = 1'b0;
      ex_mem_rd = 1'b0; ex_wr_addr = '0; id_ready = 1'b1;
      step(); step(); step();
      rst = 1'b0;

      // Reset state
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_q_count",  32'(q_count),  32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd1);
      chk("rst_redirect", 32'(redirect_valid), 32'd0);
      chk("rst_illegal",  32'(illegal),  32'd0);
      chk("rst_ext_imm",  ext_imm,       32'd0);

      // Decode table: one instruction at a time, EX always ready
      for (int i = 0; i < 12; i++) begin
         push(vecs[i].ins, 32'h1000 + 32'(4*i));
         lat = 99;
         for (int k = 0; k < 6; k++) begin
            if (id_valid) begin
               lat = k;
               break;
            end
            step();
         end
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
         chk($sformatf("v%0d_pc", i),      id_pc, 32'h1000 + 32'(4*i));
         chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].wr));
         chk($sformatf("v%0d_reg_wr", i),  32'(reg_wr),  32'(vecs[i].rw));
         chk($sformatf("v%0d_mem_rd", i),  32'(mem_rd),  32'(vecs[i].mrd));
         chk($sformatf("v%0d_mem_wr", i),  32'(mem_wr),  32'(vecs[i].mwr));
         chk($sformatf("v%0d_aluop", i),   32'(aluop),   32'(vecs[i].alu));
         chk($sformatf("v%0d_sign", i),    32'(sign),    32'(vecs[i].sgn));
         chk($sformatf("v%0d_ext_imm", i), ext_imm,      vecs[i].imm);
         chk($sformatf("v%0d_use_imm", i), 32'(use_imm), 32'(vecs[i].ui));
         chk($sformatf("v%0d_branch", i),  32'(branch),  32'(vecs[i].br));
         chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
         step();
      end
      chk("table_drained_valid", 32'(id_valid), 32'd0);

      // Backpressure: six pushes against a stalled EX, then in-order drain
      pushed = 0;
      seen   = 0;
      for (int c = 0; c < 40; c++) begin
         if_valid = (pushed < 6);
         if_pc    = 32'h2000 + 32'(4*pushed);
         if_ins   = {6'h09, 5'd0, 5'(pushed + 1), 16'(pushed)};
         id_ready = (c >= 8);
         @(negedge clk);
         acc = if_valid && if_ready;
         if (c == 6) begin
            chk("bp_q_count",  32'(q_count),  32'd4);
            chk("bp_if_ready", 32'(if_ready), 32'd0);
            chk("bp_id_valid", 32'(id_valid), 32'd1);
            chk("bp_held_pc",  id_pc,         32'h2000);
            chk("bp_held_wr",  32'(wr_addr),  32'd1);
         end
         if (id_valid && id_ready) begin
            chk($sformatf("bp_order_%0d", seen), id_pc, 32'h2000 + 32'(4*seen));
            seen++;
         end
         @(posedge clk);
         #1;
         if (acc) pushed++;
      end
      if_valid = 1'b0;
      id_ready = 1'b1;
      chk("bp_seen_count", 32'(seen), 32'd6);

      // Load-use interlock on rs, then on rt, then released by ex_wr_addr=0
      ex_mem_rd  = 1'b1;
      ex_wr_addr = 5'd3;
      push(32'h00622020, 32'h3000);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hz_rs_stall_%0d", k), 32'(id_valid), 32'd0);
         step();
      end
      chk("hz_q_count", 32'(q_count), 32'd1);
      ex_wr_addr = 5'd2;
      step();
      chk("hz_rt_stall", 32'(id_valid), 32'd0);
      ex_wr_addr = 5'd0;
      step();
      chk("hz_release_valid", 32'(id_valid), 32'd1);
      chk("hz_release_pc",    id_pc,         32'h3000);
      ex_mem_rd = 1'b0;
      step();

      // JAL with two younger entries queued behind it
      id_ready = 1'b0;
      push(32'h20010001, 32'h003F_FFFC);
      push(32'h0C000100, 32'h0040_0000);
      push(32'h20020002, 32'h0040_0004);
      push(32'h20030003, 32'h0040_0008);
      chk("jal_pre_q_count", 32'(q_count), 32'd3);
      chk("jal_pre_pc",      id_pc,        32'h003F_FFFC);
      id_ready = 1'b1;
      if_valid = 1'b1;
      if_ins   = 32'h20040004;
      if_pc    = 32'h0040_000C;
      step();
      if_valid = 1'b0;
      chk("jal_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("jal_redirect_pc",    redirect_pc,         32'h0000_0400);
      chk("jal_wr_addr",        32'(wr_addr),        32'd31);
      chk("jal_reg_wr",         32'(reg_wr),         32'd1);
      chk("jal_link_val",       link_val,            32'h0040_0008);
      chk("jal_id_pc",          id_pc,               32'h0040_0000);
      chk("jal_q_count",        32'(q_count),        32'd0);
      step();
      chk("jal_pulse_end",      32'(redirect_valid), 32'd0);
      chk("jal_no_younger",     32'(id_valid),       32'd0);
      chk("jal_q_count_after",  32'(q_count),        32'd0);

      // Flush with three entries queued and a concurrent enqueue
      id_ready = 1'b0;
      push(32'h20050005, 32'h5000);
      push(32'h20060006, 32'h5004);
      push(32'h20070007, 32'h5008);
      push(32'h20080008, 32'h500C);
      chk("fl_pre_q_count", 32'(q_count), 32'd3);
      flush    = 1'b1;
      id_ready = 1'b1;
      if_valid = 1'b1;
      if_ins   = 32'h20090009;
      if_pc    = 32'h5010;
      step();
      flush    = 1'b0;
      if_valid = 1'b0;
      chk("fl_q_count",  32'(q_count),        32'd0);
      chk("fl_id_valid", 32'(id_valid),       32'd0);
      chk("fl_redirect", 32'(redirect_valid), 32'd0);
      vcnt = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (id_valid) vcnt++;
      end
      chk("fl_nothing_issued", 32'(vcnt), 32'd0);

      // Reset in the middle of traffic
      id_ready = 1'b0;
      push(32'h200A000A, 32'h6000);
      push(32'h200B000B, 32'h6004);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_id_valid", 32'(id_valid), 32'd0);
      chk("mr_q_count",  32'(q_count),  32'd0);
      chk("mr_if_ready", 32'(if_ready), 32'd1);
      chk("mr_id_pc",    id_pc,         32'd0);
      chk("mr_wr_addr",  32'(wr_addr),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_id_queue_stage
`default_nettype wire
